// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: ID forwarding selects, load-use stall, branch flush and
// data-memory wait freeze with timeout. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned TO_CYCLES = 16,
  parameter int unsigned TO_W      = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       use_rs,
  input  logic       use_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       pcsrc_taken,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] ern,
  input  logic       mwreg,
  input  logic       mm2reg,
  input  logic [4:0] mrn,
  input  logic       mmem_req,
  input  logic       dmem_ack,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       wpcir,
  output logic       fd_flush,
  output logic       de_bubble,
  output logic       freeze,
  output logic       mw_bubble,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_lu_stall,
  output logic [31:0] perf_flush
`endif
);

  typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

  state_e          state_q;
  logic [TO_W-1:0] cnt_q;
  logic            mem_err_q;
  logic            memstall;
  logic            lu;
  logic            flush_raw;

  // EX beats MEM; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic ew, input logic em, input logic [4:0] en,
                                         input logic mw, input logic mm, input logic [4:0] mn);
    if (ew && !em && (en == src) && (en != 5'd0))      return 2'd1;
    else if (mw && !mm && (mn == src) && (mn != 5'd0)) return 2'd2;
    else if (mw && mm && (mn == src) && (mn != 5'd0))  return 2'd3;
    else                                               return 2'd0;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (mmem_req && !dmem_ack) begin
            state_q <= StMemWait;
            cnt_q   <= TO_W'(1);
          end
        end
        StMemWait: begin
          if (dmem_ack) begin
            state_q <= StRun;
            cnt_q   <= '0;
          end else if (cnt_q == TO_W'(TO_CYCLES)) begin
            state_q   <= StError;
            mem_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        StError: ;
        default: state_q <= StRun;
      endcase
    end
  end

  assign mem_err = mem_err_q;

  always_comb begin
    memstall = ((state_q == StRun) && mmem_req && !dmem_ack) ||
               ((state_q == StMemWait) && !dmem_ack) ||
               (state_q == StError);
    lu = ewreg && em2reg && (ern != 5'd0) &&
         ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));

    fwda      = fwd_sel(rs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
    fwdb      = fwd_sel(rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
    wpcir     = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    freeze    = 1'b0;
    mw_bubble = 1'b0;

    if (memstall) begin
      wpcir     = 1'b0;
      freeze    = 1'b1;
      mw_bubble = 1'b1;
    end else if (lu) begin
      wpcir     = 1'b0;
      de_bubble = 1'b1;
    end else if (pcsrc_taken) begin
      fd_flush = 1'b1;
    end
    flush_raw = fd_flush;

    // Outputs are held inactive for the whole reset, not just until the next edge.
    if (!resetn) begin
      fwda      = 2'd0;
      fwdb      = 2'd0;
      wpcir     = 1'b1;
      fd_flush  = 1'b0;
      de_bubble = 1'b0;
      freeze    = 1'b0;
      mw_bubble = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_mem_stall_q, perf_lu_stall_q, perf_flush_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      perf_mem_stall_q <= '0;
      perf_lu_stall_q  <= '0;
      perf_flush_q     <= '0;
    end else begin
      if (memstall)        perf_mem_stall_q <= perf_mem_stall_q + 32'd1;
      if (lu && !memstall) perf_lu_stall_q  <= perf_lu_stall_q + 32'd1;
      if (flush_raw)       perf_flush_q     <= perf_flush_q + 32'd1;
    end
  end

  assign perf_mem_stall = perf_mem_stall_q;
  assign perf_lu_stall  = perf_lu_stall_q;
  assign perf_flush     = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl: forwarding, load-use, memory wait,
// timeout, output priority and asynchronous reset mid-wait.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic       use_rs, use_rt, pcsrc_taken;
  logic [4:0] rs, rt, ern, mrn;
  logic       ewreg, em2reg, mwreg, mm2reg, mmem_req, dmem_ack;
  logic [1:0] fwda, fwdb;
  logic       wpcir, fd_flush, de_bubble, freeze, mw_bubble, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_mem_stall, perf_lu_stall, perf_flush;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.TO_CYCLES(16), .TO_W(5)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .use_rs      (use_rs),
    .use_rt      (use_rt),
    .rs          (rs),
    .rt          (rt),
    .pcsrc_taken (pcsrc_taken),
    .ewreg       (ewreg),
    .em2reg      (em2reg),
    .ern         (ern),
    .mwreg       (mwreg),
    .mm2reg      (mm2reg),
    .mrn         (mrn),
    .mmem_req    (mmem_req),
    .dmem_ack    (dmem_ack),
    .fwda        (fwda),
    .fwdb        (fwdb),
    .wpcir       (wpcir),
    .fd_flush    (fd_flush),
    .de_bubble   (de_bubble),
    .freeze      (freeze),
    .mw_bubble   (mw_bubble),
    .mem_err     (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_mem_stall (perf_mem_stall),
    .perf_lu_stall  (perf_lu_stall),
    .perf_flush     (perf_flush)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    {use_rs, use_rt, pcsrc_taken, ewreg, em2reg, mwreg, mm2reg, mmem_req, dmem_ack} = '0;
    rs = 5'd0; rt = 5'd0; ern = 5'd0; mrn = 5'd0;
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Packed stall outputs: {wpcir, fd_flush, de_bubble, freeze, mw_bubble}
  function automatic logic [4:0] ctl();
    return {wpcir, fd_flush, de_bubble, freeze, mw_bubble};
  endfunction

  initial begin
    clr();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    // Active inputs during reset must not reach the outputs.
    ewreg = 1'b1; ern = 5'd5; rs = 5'd5; mmem_req = 1'b1; pcsrc_taken = 1'b1;
    #1;
    check_eq("rst_fwda", 32'(fwda), 32'd0);
    check_eq("rst_ctl", 32'(ctl()), 32'b10000);
    check_eq("rst_mem_err", 32'(mem_err), 32'd0);
    #9 resetn = 1'b1;
    clr();
    step();

    // Forwarding
    ewreg = 1'b1; ern = 5'd5; mwreg = 1'b1; mm2reg = 1'b1; mrn = 5'd5; rs = 5'd5; rt = 5'd0;
    #1;
    check_eq("fwd_ex_wins", 32'(fwda), 32'd1);
    check_eq("fwd_rt_r0", 32'(fwdb), 32'd0);
    check_eq("fwd_no_stall", 32'(ctl()), 32'b10000);
    ewreg = 1'b0; #1;
    check_eq("fwd_mem_load", 32'(fwda), 32'd3);
    mm2reg = 1'b0; rt = 5'd5; #1;
    check_eq("fwd_mem_alu_a", 32'(fwda), 32'd2);
    check_eq("fwd_mem_alu_b", 32'(fwdb), 32'd2);
    mrn = 5'd0; rs = 5'd0; #1;
    check_eq("fwd_r0_never", 32'(fwda), 32'd0);

    // Load-use
    clr(); step();
    ewreg = 1'b1; em2reg = 1'b1; ern = 5'd8; use_rt = 1'b1; rt = 5'd8; #1;
    check_eq("lu_stall", 32'(ctl()), 32'b00100);
    step(); ern = 5'd9; #1;
    check_eq("lu_cleared", 32'(ctl()), 32'b10000);
    step(); ern = 5'd0; rt = 5'd0; #1;
    check_eq("lu_r0_none", 32'(ctl()), 32'b10000);

    // Memory wait of 3 cycles
    clr(); step();
    mmem_req = 1'b1; #1;
    check_eq("mw_c1", 32'(ctl()), 32'b00011);
    step();
    check_eq("mw_c2", 32'(ctl()), 32'b00011);
    step();
    check_eq("mw_c3", 32'(ctl()), 32'b00011);
    step(); dmem_ack = 1'b1; #1;
    check_eq("mw_ack", 32'(ctl()), 32'b10000);
    step(); mmem_req = 1'b0; dmem_ack = 1'b0; #1;
    check_eq("mw_back_run", 32'(freeze), 32'd0);

    // Zero-wait access
    step(); mmem_req = 1'b1; dmem_ack = 1'b1; #1;
    check_eq("zw_no_freeze", 32'(freeze), 32'd0);
    step(); mmem_req = 1'b0; dmem_ack = 1'b0; #1;
    check_eq("zw_stays_run", 32'(freeze), 32'd0);

    // Timeout: 1 RUN stall edge plus 16 MEMWAIT edges
    mmem_req = 1'b1; #1;
    for (int i = 0; i < 16; i++) step();
    check_eq("to_not_yet", 32'(mem_err), 32'd0);
    check_eq("to_freeze", 32'(freeze), 32'd1);
    step();
    check_eq("to_err", 32'(mem_err), 32'd1);
    mmem_req = 1'b0; dmem_ack = 1'b1; step();
    check_eq("to_absorb_freeze", 32'(freeze), 32'd1);
    check_eq("to_absorb_err", 32'(mem_err), 32'd1);
    #2 resetn = 1'b0; #1;
    check_eq("to_rst_err", 32'(mem_err), 32'd0);
    check_eq("to_rst_freeze", 32'(freeze), 32'd0);
    #1 resetn = 1'b1;
    clr(); step();
    check_eq("to_after_rst", 32'(ctl()), 32'b10000);

    // Priority: memstall > lu > pcsrc_taken
    mmem_req = 1'b1; ewreg = 1'b1; em2reg = 1'b1; ern = 5'd8; use_rs = 1'b1; rs = 5'd8;
    pcsrc_taken = 1'b1; #1;
    check_eq("pri_mem_c1", 32'(ctl()), 32'b00011);
    step();
    check_eq("pri_mem_c2", 32'(ctl()), 32'b00011);
    step(); dmem_ack = 1'b1; #1;
    check_eq("pri_lu", 32'(ctl()), 32'b00100);
    step(); mmem_req = 1'b0; dmem_ack = 1'b0; ewreg = 1'b0; #1;
    check_eq("pri_flush", 32'(ctl()), 32'b11000);
    step(); pcsrc_taken = 1'b0; #1;
    check_eq("pri_idle", 32'(ctl()), 32'b10000);

    // Reset during cycle 2 of a wait
    clr(); step();
    mmem_req = 1'b1; step(); step();
    check_eq("rmw_waiting", 32'(freeze), 32'd1);
    #2 resetn = 1'b0; #1;
    check_eq("rmw_async", 32'(ctl()), 32'b10000);
    #3 resetn = 1'b1;
    mmem_req = 1'b0; #1;
    check_eq("rmw_run", 32'(freeze), 32'd0);
    step();
    check_eq("rmw_run_edge", 32'(freeze), 32'd0);
    mmem_req = 1'b1; step(); dmem_ack = 1'b1; #1;
    check_eq("rmw_new_wait_ack", 32'(freeze), 32'd0);
    step(); clr(); #1;
    check_eq("rmw_done", 32'(ctl()), 32'b10000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Computes ID-stage operand forwarding selects from the EX/MEM/WB destination fields.
- Detects load-use hazards and flushes IF/ID on taken branches.
- Freezes the whole pipeline while a MEM-stage data-memory access waits for acknowledge, with a timeout that latches a sticky error.

Parameters:
- TO_CYCLES, 16: number of MEMWAIT cycles without ack before entering ERROR.
- TO_W, 5: width of the wait counter; must hold TO_CYCLES.

Ports:
- clock  in  1  pipeline clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- use_rs  in  1  ID instruction reads rs.
- use_rt  in  1  ID instruction reads rt.
- rs  in  5  ID source register A.
- rt  in  5  ID source register B.
- pcsrc_taken  in  1  ID branch/jump resolved taken.
- ewreg  in  1  EX writes a register.
- em2reg  in  1  EX instruction is a load.
- ern  in  5  EX destination register.
- mwreg  in  1  MEM writes a register.
- mm2reg  in  1  MEM instruction is a load.
- mrn  in  5  MEM destination register.
- mmem_req  in  1  MEM instruction accesses data memory.
- dmem_ack  in  1  data memory completes the access this cycle.
- fwda  out  2  rs operand select: 0 regfile, 1 EX alu, 2 MEM alu, 3 MEM mem data.
- fwdb  out  2  rt operand select; same encoding as fwda.
- wpcir  out  1  PC and IF/ID write enable.
- fd_flush  out  1  clear IF/ID to a nop.
- de_bubble  out  1  load zeros (control) into ID/EX.
- freeze  out  1  hold ID/EX and EX/MEM.
- mw_bubble  out  1  load wwreg=0, wm2reg=0 into MEM/WB.
- mem_err  out  1  sticky memory timeout flag.

Behaviour:
- Reset: resetn is asynchronous, active-low; the clock is clock. While resetn=0:
  - state=RUN, wait counter=0, mem_err=0.
  - All combinational outputs forced to fwda=0, fwdb=0, wpcir=1, fd_flush=0, de_bubble=0, freeze=0, mw_bubble=0.
  - Reset asserted mid-wait aborts to RUN immediately; no pending state survives.
- Forwarding (combinational, evaluated for rs and rt independently):
  - Select 1 if ewreg & !em2reg & ern==src & ern!=0.
  - Else 2 if mwreg & !mm2reg & mrn==src & mrn!=0.
  - Else 3 if mwreg & mm2reg & mrn==src & mrn!=0.
  - Else 0.
  - EX always wins over MEM. Register 0 never forwards.
  - Forwarding is independent of use_rs/use_rt.
- Load-use hazard: lu = ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)).
- FSM states RUN, MEMWAIT, ERROR:
  - RUN -> MEMWAIT when mmem_req & !dmem_ack. Counter loads 1.
  - RUN stays RUN when mmem_req & dmem_ack in the same cycle. There is no stall for a zero-wait access.
  - MEMWAIT -> RUN on dmem_ack.
  - MEMWAIT with !dmem_ack increments the counter. When the counter==TO_CYCLES, next state is ERROR and mem_err is set.
  - ERROR is absorbing until reset.
- memstall = (RUN & mmem_req & !dmem_ack) | (MEMWAIT & !dmem_ack) | ERROR. This is Mealy: an ack releases the freeze in the same cycle.
- Output priority: memstall > lu > pcsrc_taken.
  - memstall: wpcir=0, freeze=1, mw_bubble=1, de_bubble=0, fd_flush=0.
  - lu (no memstall): wpcir=0, de_bubble=1, freeze=0, mw_bubble=0, fd_flush=0.
  - pcsrc_taken (no stall): fd_flush=1, wpcir=1.
  - None of the above: wpcir=1, all others 0.
- A taken branch coinciding with a stall is not lost. The ID instruction is held, so pcsrc_taken is presented again and is honoured once stalls clear.
- The counter saturates at TO_CYCLES and does not wrap.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, add three 32-bit outputs: perf_mem_stall, perf_lu_stall, perf_flush.
  - Each increments on every clock edge in which memstall, lu-without-memstall, or fd_flush is respectively active.
  - Each wraps modulo 2^32 and resets to 0 on resetn.
- When undefined, these ports and registers do not exist and the remaining behaviour is identical.

Test Plan:
- Forwarding, EX and MEM both match: ewreg=1, em2reg=0, ern=5; mwreg=1, mm2reg=1, mrn=5; rs=5, rt=0 -> fwda=1 (EX wins), fwdb=0.
- Load-use: ewreg=1, em2reg=1, ern=8, use_rt=1, rt=8 -> for one cycle wpcir=0, de_bubble=1. The next cycle, with ern changed, wpcir=1. A repeat with ern=0 -> no stall.
- Memory wait: mmem_req=1, dmem_ack low for 3 cycles then high -> freeze=1, mw_bubble=1, wpcir=0 for exactly 3 cycles. freeze=0 in the ack cycle; state returns to RUN.
- Zero-wait access and timeout: mmem_req=1 with dmem_ack=1 -> no freeze. mmem_req=1 with dmem_ack held 0 and TO_CYCLES=16 -> mem_err=1 after the 16th MEMWAIT cycle; freeze stays 1 until resetn pulses low, after which mem_err=0 and freeze=0.
- Priority: memstall, lu and pcsrc_taken all active -> only the memstall outputs assert (fd_flush=0). When ack arrives, lu wins. After that clears, fd_flush=1 for one cycle.
- Reset mid-MEMWAIT: resetn low during cycle 2 of a wait -> outputs go inactive asynchronously; after release, state is RUN with counter 0.
